// File: rtl/gnrc_codec_pkg.sv
// Shared thermometer-codec helpers.
//   ERR_W_DEFAULT : default width of saturating error counters
//   THERM_MAX_W   : widest thermometer code the helpers accept (N <= 6)
//   therm_popcount: number of set bits in a zero-extended thermometer code
//   therm_is_valid: 1 when the code has the form 0..01..1 (all-zero included)
package gnrc_codec_pkg;

    localparam int unsigned ERR_W_DEFAULT = 8;
    localparam int unsigned THERM_MAX_W   = 63;
    localparam int unsigned POP_W         = 6;

    // Plain ripple count; the synthesizer builds the adder tree.
    function automatic logic [POP_W-1:0] therm_popcount(input logic [THERM_MAX_W-1:0] v);
        logic [POP_W-1:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < THERM_MAX_W; i++) begin
            cnt = cnt + POP_W'(v[i]);
        end
        return cnt;
    endfunction

    // A monotonic code plus one is a power of two, so it shares no set bit with itself.
    function automatic logic therm_is_valid(input logic [THERM_MAX_W-1:0] t);
        return (t & (t + THERM_MAX_W'(1))) == '0;
    endfunction

endpackage

// File: rtl/gnrc_therm_popcount.sv
// Combinational popcount of a (2^N-1)-bit thermometer code into N bits.
//   therm_i : thermometer code, M = 2^N-1 bits
//   bin_o   : number of set bits in therm_i (max 2^N-1, always fits N bits)
module gnrc_therm_popcount
    import gnrc_codec_pkg::*;
#(
    parameter  int unsigned N = 3,
    localparam int unsigned M = (1 << N) - 1
) (
    input  logic [M-1:0] therm_i,
    output logic [N-1:0] bin_o
);

    assign bin_o = N'(therm_popcount(THERM_MAX_W'(therm_i)));

endmodule

// File: rtl/gnrc_therm2bin_pipe.sv
// Two-stage valid/ready thermometer-to-binary decoder with bubble detection
// and a saturating count of erroneous beats delivered downstream.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   therm_i/valid_i  : upstream thermometer beat;   ready_o : upstream accept
//   bin_o/err_o      : decoded value and bubble flag; valid_o : output beat valid
//   ready_i          : downstream accept
//   err_cnt_o        : erroneous beats delivered, saturating; err_clr_i clears it
module gnrc_therm2bin_pipe
    import gnrc_codec_pkg::*;
#(
    parameter  int unsigned N          = 3,
    localparam int unsigned M          = (1 << N) - 1,
    parameter  int unsigned BUBBLE_FIX = 1,
    parameter  int unsigned ERR_W      = ERR_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [M-1:0]     therm_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [N-1:0]     bin_o,
    output logic             err_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [ERR_W-1:0] err_cnt_o,
    input  logic             err_clr_i
);

    logic             s1_valid_q, s1_valid_d;
    logic [M-1:0]     s1_therm_q, s1_therm_d;
    logic             s2_valid_q, s2_valid_d;
    logic [N-1:0]     bin_q, bin_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;

    logic             s1_ld, s2_ld;
    logic [N-1:0]     dec_bin;
    logic             dec_err;

    // Decode of the stage-1 code, mode selected at elaboration.
    if (BUBBLE_FIX != 0) begin : g_pop
        gnrc_therm_popcount #(.N(N)) u_pop (
            .therm_i (s1_therm_q),
            .bin_o   (dec_bin)
        );
    end else begin : g_hi
        // Highest set bit index + 1; later bits overwrite earlier ones.
        always_comb begin
            dec_bin = '0;
            for (int unsigned k = 0; k < M; k++) begin
                if (s1_therm_q[k]) begin
                    dec_bin = N'(k + 1);
                end
            end
        end
    end

    assign dec_err = ~therm_is_valid(THERM_MAX_W'(s1_therm_q));

    // Handshake, stage advance and error counter next-state.
    always_comb begin
        s2_ld      = s1_valid_q & (~s2_valid_q | ready_i);
        // Held low during reset so no upstream beat is accepted and then discarded.
        ready_o    = ~rst_i & (~s1_valid_q | s2_ld);
        s1_ld      = valid_i & ready_o;

        s1_valid_d = s1_ld | (s1_valid_q & ~s2_ld);
        s1_therm_d = s1_therm_q;
        s2_valid_d = s2_ld | (s2_valid_q & ~ready_i);
        bin_d      = bin_q;
        err_d      = err_q;
        cnt_d      = cnt_q;

        if (s1_ld) begin
            s1_therm_d = therm_i;
        end
        if (s2_ld) begin
            bin_d = dec_bin;
            err_d = dec_err;
        end
        if (err_clr_i) begin
            cnt_d = '0;
        end else if (s2_valid_q & ready_i & err_q & ~(&cnt_q)) begin
            cnt_d = cnt_q + ERR_W'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_therm_q <= '0;
            s2_valid_q <= 1'b0;
            bin_q      <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_therm_q <= s1_therm_d;
            s2_valid_q <= s2_valid_d;
            bin_q      <= bin_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign valid_o   = s2_valid_q;
    assign bin_o     = bin_q;
    assign err_o     = err_q;
    assign err_cnt_o = cnt_q;

endmodule

// File: tb/tb_gnrc_therm2bin_pipe.sv
// Directed and randomized checks of gnrc_therm2bin_pipe (N=3) in both decode modes.
module tb_gnrc_therm2bin_pipe;

    localparam int unsigned N     = 3;
    localparam int unsigned M     = 7;
    localparam int unsigned ERR_W = 8;
    localparam int unsigned BEATS = 10000;
    localparam int unsigned LIMIT = 60000;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [M-1:0]     therm_i;
    logic             valid_i;
    logic             ready_i;
    logic             err_clr_i;

    logic             ready_o,   nb_ready_o;
    logic [N-1:0]     bin_o,     nb_bin_o;
    logic             err_o,     nb_err_o;
    logic             valid_o,   nb_valid_o;
    logic [ERR_W-1:0] err_cnt_o, nb_err_cnt_o;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    always #5 clk_i = ~clk_i;

    gnrc_therm2bin_pipe #(.N(N), .BUBBLE_FIX(1), .ERR_W(ERR_W)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .therm_i   (therm_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .bin_o     (bin_o),
        .err_o     (err_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .err_cnt_o (err_cnt_o),
        .err_clr_i (err_clr_i)
    );

    gnrc_therm2bin_pipe #(.N(N), .BUBBLE_FIX(0), .ERR_W(ERR_W)) dut_nb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .therm_i   (therm_i),
        .valid_i   (valid_i),
        .ready_o   (nb_ready_o),
        .bin_o     (nb_bin_o),
        .err_o     (nb_err_o),
        .valid_o   (nb_valid_o),
        .ready_i   (ready_i),
        .err_cnt_o (nb_err_cnt_o),
        .err_clr_i (err_clr_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int unsigned m_pop(input logic [M-1:0] t);
        int unsigned c = 0;
        for (int i = 0; i < int'(M); i++) c += 32'(t[i]);
        return c;
    endfunction

    function automatic int unsigned m_hi(input logic [M-1:0] t);
        int unsigned h = 0;
        for (int i = 0; i < int'(M); i++) if (t[i]) h = 32'(i + 1);
        return h;
    endfunction

    function automatic logic m_err(input logic [M-1:0] t);
        logic e = 1'b0;
        for (int i = 1; i < int'(M); i++) if (t[i] && !t[i-1]) e = 1'b1;
        return e;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [M-1:0] stream_v [4];
        int unsigned  stream_e [4];
        logic [M-1:0] q [$];
        logic [M-1:0] t;
        logic         acc, outh, hold, clr;
        int unsigned  m_cnt, n_in, n_out, cyc, k;

        stream_v[0] = 7'b0000000; stream_e[0] = 0;
        stream_v[1] = 7'b0000001; stream_e[1] = 1;
        stream_v[2] = 7'b0000111; stream_e[2] = 3;
        stream_v[3] = 7'b1111111; stream_e[3] = 7;

        rst_i = 1'b1; therm_i = '0; valid_i = 1'b0; ready_i = 1'b1; err_clr_i = 1'b0;
        repeat (3) step();
        rst_i = 1'b0;
        #1;
        chk("rst_valid_o", 32'(valid_o), 0);
        chk("rst_bin_o", 32'(bin_o), 0);
        chk("rst_err_o", 32'(err_o), 0);
        chk("rst_err_cnt", 32'(err_cnt_o), 0);
        chk("rst_ready_o", 32'(ready_o), 1);

        // Back-to-back valid codes, two-cycle latency.
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                therm_i = stream_v[c]; valid_i = 1'b1;
            end else begin
                valid_i = 1'b0;
            end
            step();
            if (c >= 1 && c <= 4) begin
                chk("strm_valid", 32'(valid_o), 1);
                chk("strm_bin", 32'(bin_o), stream_e[c-1]);
                chk("strm_err", 32'(err_o), 0);
                chk("strm_bin_nb", 32'(nb_bin_o), stream_e[c-1]);
            end
            if (c == 5) chk("strm_drain", 32'(valid_o), 0);
        end

        // Bubbled code in both decode modes.
        therm_i = 7'b0000101; valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        step();
        chk("bub_valid", 32'(valid_o), 1);
        chk("bub_bin_pop", 32'(bin_o), 2);
        chk("bub_err_pop", 32'(err_o), 1);
        chk("bub_bin_hi", 32'(nb_bin_o), 3);
        chk("bub_err_hi", 32'(nb_err_o), 1);
        chk("bub_cnt_before", 32'(err_cnt_o), 0);
        step();
        chk("bub_cnt_after", 32'(err_cnt_o), 1);
        chk("bub_valid_after", 32'(valid_o), 0);

        // Fill with downstream stalled, then release.
        ready_i = 1'b0;
        therm_i = 7'b0000011; valid_i = 1'b1;
        step();
        therm_i = 7'b0001111;
        step();
        therm_i = 7'b0111111;
        #1;
        chk("fill_ready_lo", 32'(ready_o), 0);
        chk("fill_valid", 32'(valid_o), 1);
        chk("fill_bin0", 32'(bin_o), 2);
        step();
        step();
        chk("fill_hold_bin", 32'(bin_o), 2);
        chk("fill_hold_valid", 32'(valid_o), 1);
        #1;
        chk("fill_ready_hold", 32'(ready_o), 0);
        ready_i = 1'b1;
        #1;
        chk("fill_ready_comb", 32'(ready_o), 1);
        step();
        valid_i = 1'b0;
        chk("fill_out1", 32'(bin_o), 4);
        chk("fill_out1_v", 32'(valid_o), 1);
        step();
        chk("fill_out2", 32'(bin_o), 6);
        chk("fill_out2_v", 32'(valid_o), 1);
        step();
        chk("fill_empty", 32'(valid_o), 0);

        // Saturation of the error counter.
        therm_i = 7'b0000101; valid_i = 1'b1;
        repeat (100) step();
        valid_i = 1'b0;
        repeat (4) step();
        chk("sat_cnt_101", 32'(err_cnt_o), 101);
        valid_i = 1'b1;
        repeat (200) step();
        valid_i = 1'b0;
        repeat (4) step();
        chk("sat_cnt_255", 32'(err_cnt_o), 255);
        chk("sat_cnt_255_nb", 32'(nb_err_cnt_o), 255);

        // Clear wins over a concurrent erroneous delivery.
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        step();
        chk("clr_err_beat", 32'(err_o & valid_o), 1);
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        chk("clr_cnt", 32'(err_cnt_o), 0);
        step();
        chk("clr_cnt_hold", 32'(err_cnt_o), 0);

        // Reset with both stages full.
        ready_i = 1'b0; therm_i = 7'b0000101; valid_i = 1'b1;
        step();
        step();
        #1;
        chk("rstm_full", 32'(ready_o), 0);
        therm_i = 7'b1111111; ready_i = 1'b1; rst_i = 1'b1;
        step();
        rst_i = 1'b0; valid_i = 1'b0;
        #1;
        chk("rstm_valid_o", 32'(valid_o), 0);
        chk("rstm_bin_o", 32'(bin_o), 0);
        chk("rstm_err_cnt", 32'(err_cnt_o), 0);
        chk("rstm_ready_o", 32'(ready_o), 1);
        step();
        chk("rstm_no_ghost", 32'(valid_o), 0);

        // Random handshakes against a queue model.
        m_cnt = 0; n_in = 0; n_out = 0; cyc = 0; hold = 1'b0;
        while (n_out < BEATS && cyc < LIMIT) begin
            if (!hold) begin
                if (n_in < BEATS && $urandom_range(3, 0) != 0) begin
                    if ($urandom_range(1, 0) == 1) begin
                        k = $urandom_range(7, 0);
                        t = 7'((32'd1 << k) - 1);
                    end else begin
                        t = 7'($urandom);
                    end
                    therm_i = t; valid_i = 1'b1;
                end else begin
                    valid_i = 1'b0;
                end
            end
            ready_i   = ($urandom_range(3, 0) != 0);
            clr       = ($urandom_range(63, 0) == 0);
            err_clr_i = clr;
            #1;
            chk("rnd_cnt", 32'(err_cnt_o), m_cnt);
            acc  = valid_i & ready_o;
            outh = valid_o & ready_i;
            if (outh) begin
                chk("rnd_q_nonempty", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    t = q.pop_front();
                    chk("rnd_bin", 32'(bin_o), m_pop(t));
                    chk("rnd_err", 32'(err_o), 32'(m_err(t)));
                    chk("rnd_bin_nb", 32'(nb_bin_o), m_hi(t));
                    if (!clr && m_err(t) && m_cnt < 255) m_cnt++;
                end
                n_out++;
            end
            if (clr) m_cnt = 0;
            if (acc) begin
                q.push_back(therm_i);
                n_in++;
            end
            hold = valid_i & ~acc;
            step();
            cyc++;
        end
        valid_i = 1'b0; ready_i = 1'b0; err_clr_i = 1'b0;
        chk("rnd_beats_out", n_out, BEATS);
        chk("rnd_q_empty", 32'(q.size()), 0);
        #1;
        chk("rnd_cnt_final", 32'(err_cnt_o), m_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
